fifo_sc: RTL and testbench

Parametrised single-clock synchronous FIFO built around an internal simple-dual-port RAM array. It generalises the team's RAM primitive into a complete buffer with pointer management, occupancy count, programmable almost-full/almost-empty thresholds and sticky-free error pulses. It sits between producer and consumer stages that share one clock domain, and is the default elastic buffer for the `fifo_pkg` family.

---
 rtl/fifo_sc_if.sv | 30 +++
 rtl/fifo_sc.sv | 108 ++++++++++
 tb/tb_fifo_sc.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fifo_sc_if.sv
// Producer/consumer-facing signal bundle of the single-clock FIFO.
// The FIFO takes the slave modport; the surrounding stages drive the master side.
interface fifo_sc_if #(
   parameter int W_DATA  = 8,
   parameter int W_DEPTH = 16
);
   localparam int W_ADDR = $clog2(W_DEPTH);

   logic              push;
   logic [W_DATA-1:0] data_in;
   logic              pop;
   logic [W_DATA-1:0] data_out;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [W_ADDR:0]   count;
   logic              overflow;
   logic              underflow;

   modport master (
      output push, data_in, pop,
      input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  push, data_in, pop,
      output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_sc.sv
// Single-clock synchronous FIFO with occupancy count, threshold flags and overflow/underflow pulses.
// Define FIFO_SC_FWFT_EN for first-word-fall-through reads; otherwise data_out is registered (1-cycle latency).
module fifo_sc #(
   parameter int W_DATA   = 8,
   parameter int W_DEPTH  = 16,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 4
) (
   input logic      clk,
   input logic      rst,
   fifo_sc_if.slave bus
);
   localparam int W_ADDR = $clog2(W_DEPTH);

   localparam logic [W_ADDR:0] C_ONE   = 1;
   localparam logic [W_ADDR:0] C_DEPTH = W_DEPTH[W_ADDR:0];
   localparam logic [W_ADDR:0] C_AF    = AF_LEVEL[W_ADDR:0];
   localparam logic [W_ADDR:0] C_AE    = AE_LEVEL[W_ADDR:0];

   logic [W_DATA-1:0] r_ram [W_DEPTH];
   logic [W_ADDR:0]   r_wr_ptr;
   logic [W_ADDR:0]   r_rd_ptr;
   logic [W_ADDR:0]   r_count;
   logic              r_full;
   logic              r_empty;
   logic              r_almost_full;
   logic              r_almost_empty;
   logic              r_overflow;
   logic              r_underflow;

   logic              w_push_ok;
   logic              w_pop_ok;
   logic [W_ADDR:0]   w_count_nxt;

   // A push at full is still taken when a pop frees a slot in the same cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_push_ok   = bus.push && (!r_full || bus.pop);
      w_pop_ok    = bus.pop && !r_empty;
      w_count_nxt = r_count;
      if (w_push_ok && !w_pop_ok) begin
         w_count_nxt = r_count + C_ONE;
      end else if (w_pop_ok && !w_push_ok) begin
         w_count_nxt = r_count - C_ONE;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + C_ONE;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + C_ONE;
         end
         // Flags come from the next-state count so they are exact right after the edge.
         r_count        <= w_count_nxt;
         r_full         <= (w_count_nxt == C_DEPTH);
         r_empty        <= (w_count_nxt == '0);
         r_almost_full  <= (w_count_nxt >= C_AF);
         r_almost_empty <= (w_count_nxt <= C_AE);
         r_overflow     <= bus.push && !w_push_ok;
         r_underflow    <= bus.pop && !w_pop_ok;
      end
   end

   // NOTE: the storage array has no reset; emptiness is tracked by the pointers and count alone.
   always_ff @(posedge clk) begin
      if (!rst && w_push_ok) begin
         r_ram[r_wr_ptr[W_ADDR-1:0]] <= bus.data_in;
      end
   end

`ifdef FIFO_SC_FWFT_EN
   assign bus.data_out = r_ram[r_rd_ptr[W_ADDR-1:0]];
`else
   logic [W_DATA-1:0] r_data_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data_out <= '0;
      end else if (w_pop_ok) begin
         r_data_out <= r_ram[r_rd_ptr[W_ADDR-1:0]];
      end
   end

   assign bus.data_out = r_data_out;
`endif

   assign bus.full         = r_full;
   assign bus.empty        = r_empty;
   assign bus.almost_full  = r_almost_full;
   assign bus.almost_empty = r_almost_empty;
   assign bus.count        = r_count;
   assign bus.overflow     = r_overflow;
   assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_sc.sv
// Directed and randomized bench for fifo_sc against a queue-based reference model.
// The model tracks contents as a queue; flags and pulses are derived from its size.
module tb_fifo_sc;
   localparam int W_DATA   = 8;
   localparam int W_DEPTH  = 16;
   localparam int AF_LEVEL = 12;
   localparam int AE_LEVEL = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fifo_sc_if #(.W_DATA(W_DATA), .W_DEPTH(W_DEPTH)) bus ();

   fifo_sc #(
      .W_DATA  (W_DATA),
      .W_DEPTH (W_DEPTH),
      .AF_LEVEL(AF_LEVEL),
      .AE_LEVEL(AE_LEVEL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [W_DATA-1:0] model_q [$];
   logic [W_DATA-1:0] exp_dout;
   logic              exp_ovf;
   logic              exp_unf;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = model_q.size();
      check({tag, " count"},        32'(bus.count),        32'(n));
      check({tag, " full"},         32'(bus.full),         32'(n == W_DEPTH));
      check({tag, " empty"},        32'(bus.empty),        32'(n == 0));
      check({tag, " almost_full"},  32'(bus.almost_full),  32'(n >= AF_LEVEL));
      check({tag, " almost_empty"}, 32'(bus.almost_empty), 32'(n <= AE_LEVEL));
      check({tag, " overflow"},     32'(bus.overflow),     32'(exp_ovf));
      check({tag, " underflow"},    32'(bus.underflow),    32'(exp_unf));
`ifdef FIFO_SC_FWFT_EN
      if (n > 0) begin
         check({tag, " data_out"}, 32'(bus.data_out), 32'(model_q[0]));
      end
`else
      check({tag, " data_out"}, 32'(bus.data_out), 32'(exp_dout));
`endif
   endtask

   // Apply one cycle of stimulus, advance the model by the FIFO's acceptance rules, then compare.
   task automatic step(input logic p, input logic [W_DATA-1:0] d, input logic q, input string tag);
      int   n;
      logic push_ok;
      logic pop_ok;
      n           = model_q.size();
      bus.push    = p;
      bus.data_in = d;
      bus.pop     = q;
      pop_ok      = q && (n > 0);
      push_ok     = p && ((n < W_DEPTH) || q);
      exp_ovf     = p && !push_ok;
      exp_unf     = q && !pop_ok;
      if (pop_ok) exp_dout = model_q.pop_front();
      if (push_ok) model_q.push_back(d);
      @(posedge clk);
      #1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      check_all(tag);
   endtask

   task automatic do_reset(input logic p, input logic [W_DATA-1:0] d, input string tag);
      rst         = 1'b1;
      bus.push    = p;
      bus.data_in = d;
      bus.pop     = 1'b0;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      bus.push = 1'b0;
      model_q.delete();
      exp_dout = '0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
      check_all(tag);
   endtask

   initial begin
      logic [W_DATA-1:0] seq;
      bus.push    = 1'b0;
      bus.pop     = 1'b0;
      bus.data_in = '0;
      exp_dout    = '0;
      exp_ovf     = 1'b0;
      exp_unf     = 1'b0;

      do_reset(1'b0, '0, "reset");
      step(1'b0, '0, 1'b0, "idle");

      // Fill to full, then one rejected push and an idle cycle to see the pulse drop.
      for (int i = 0; i < W_DEPTH; i++) step(1'b1, W_DATA'(i), 1'b0, $sformatf("fill%0d", i));
      step(1'b1, 8'hEE, 1'b0, "push_full");
      step(1'b0, '0, 1'b0, "after_ovf");

      // Drain in order, then one rejected pop.
      for (int i = 0; i < W_DEPTH; i++) step(1'b0, '0, 1'b1, $sformatf("drain%0d", i));
      step(1'b0, '0, 1'b1, "pop_empty");
      step(1'b0, '0, 1'b0, "after_unf");

      // Refill and stream through a full FIFO across several pointer wraps.
      seq = 8'h40;
      for (int i = 0; i < W_DEPTH; i++) begin
         step(1'b1, seq, 1'b0, "refill");
         seq++;
      end
      for (int i = 0; i < 40; i++) begin
         step(1'b1, seq, 1'b1, $sformatf("stream%0d", i));
         seq++;
      end
      for (int i = 0; i < W_DEPTH; i++) step(1'b0, '0, 1'b1, "drain2");

      // Push and pop together while empty: pop rejected, push taken.
      step(1'b1, 8'hA5, 1'b1, "push_pop_empty");
      step(1'b0, '0, 1'b0, "hold_a5");

      // Reach count 9, then reset with a concurrent push that must be ignored.
      for (int i = 0; i < 8; i++) step(1'b1, 8'h90 + W_DATA'(i), 1'b0, "to_nine");
      do_reset(1'b1, 8'h77, "reset_mid");
      step(1'b1, 8'h3C, 1'b0, "post_rst_push");
      step(1'b0, '0, 1'b1, "post_rst_pop");

      // Random traffic: push-heavy phase then pop-heavy phase.
      for (int i = 0; i < 400; i++) begin
         int bias;
         bias = (i < 200) ? 70 : 30;
         step($urandom_range(0, 99) < bias, W_DATA'($urandom),
              $urandom_range(0, 99) >= bias, $sformatf("rand%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
